branch_resolver: RTL and testbench

//  EX-stage branch resolution unit; the producer side of the fetch redirect/BTB-update interface.

---
 rtl/branch_resolver.sv | 183 ++++++++++++++++++
 tb/tb_branch_resolver.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// EX-stage branch resolver: evaluates B/JAL/JALR, flags mispredicts with a one-cycle
// redirect pulse and then holds flush for a fixed squash window. Optional BRANCH_STATS_EN.
module branch_resolver #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned SQUASH_CYCLES = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  stall_ex,
    input  logic                  ex_valid,
    input  logic [ADDR_WIDTH-1:0] ex_pc,
    input  logic                  ex_is_branch,
    input  logic                  ex_is_jal,
    input  logic                  ex_is_jalr,
    input  logic [2:0]            ex_funct3,
    input  logic [ADDR_WIDTH-1:0] ex_rs1,
    input  logic [ADDR_WIDTH-1:0] ex_rs2,
    input  logic [ADDR_WIDTH-1:0] ex_imm,
    input  logic                  ex_pred_taken,
    input  logic [ADDR_WIDTH-1:0] ex_pred_target,
    output logic                  branch_flag_out,
    output logic [ADDR_WIDTH-1:0] branch_target_out,
    output logic [ADDR_WIDTH-1:0] branch_pc_out,
    output logic                  branch_taken_out,
    output logic                  is_jalr_out,
    output logic [ADDR_WIDTH-1:0] link_addr_out,
`ifdef BRANCH_STATS_EN
    output logic [31:0]           stat_resolved_out,
    output logic [31:0]           stat_mispredict_out,
`endif
    output logic                  flush_out
);

    localparam int unsigned CNT_W = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        SQUASH   = 2'd2
    } state_t;

    state_t                state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;

    logic                  cond;
    logic                  is_cf;
    logic                  actual_taken;
    logic [ADDR_WIDTH-1:0] taken_target;
    logic [ADDR_WIDTH-1:0] seq_pc;
    logic [ADDR_WIDTH-1:0] actual_next;
    logic                  mispredict;
    logic                  consume;

    logic                  flag_d;
    logic                  flush_d;
    logic [ADDR_WIDTH-1:0] target_d;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic                  taken_d;
    logic                  jalr_d;
    logic [ADDR_WIDTH-1:0] link_d;

    // Outcome and target evaluation for the instruction currently in EX
    always_comb begin
        cond = 1'b0;
        case (ex_funct3)
            3'b000:  cond = (ex_rs1 == ex_rs2);
            3'b001:  cond = (ex_rs1 != ex_rs2);
            3'b100:  cond = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'b101:  cond = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'b110:  cond = (ex_rs1 <  ex_rs2);
            3'b111:  cond = (ex_rs1 >= ex_rs2);
            default: cond = 1'b0;
        endcase
        is_cf        = ex_is_branch | ex_is_jal | ex_is_jalr;
        actual_taken = ex_is_jal | ex_is_jalr | (ex_is_branch & cond);
        taken_target = ex_is_jalr ? ((ex_rs1 + ex_imm) & {{(ADDR_WIDTH-1){1'b1}}, 1'b0})
                                  : (ex_pc + ex_imm);
        seq_pc       = ex_pc + ADDR_WIDTH'(4);
        actual_next  = actual_taken ? taken_target : seq_pc;
        mispredict   = (actual_taken != ex_pred_taken) |
                       (actual_taken & (taken_target != ex_pred_target));
        consume      = rdy_in & ~stall_ex & ex_valid & is_cf & (state == IDLE);
    end

    // State register
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Next-state logic; REDIRECT/SQUASH ignore stall_ex but still freeze on rdy_in=0
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (rdy_in) begin
            case (state)
                IDLE: begin
                    if (consume && mispredict) begin
                        state_d = REDIRECT;
                    end
                end
                REDIRECT: begin
                    state_d = SQUASH;
                    cnt_d   = CNT_W'(SQUASH_CYCLES - 1);
                end
                SQUASH: begin
                    if (cnt == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt - CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs
    always_comb begin
        flag_d   = branch_flag_out;
        flush_d  = flush_out;
        target_d = branch_target_out;
        pc_d     = branch_pc_out;
        taken_d  = branch_taken_out;
        jalr_d   = is_jalr_out;
        link_d   = link_addr_out;
        if (rdy_in) begin
            flag_d  = (state_d == REDIRECT);
            flush_d = (state_d != IDLE);
            if (consume) begin
                target_d = actual_next;
                pc_d     = ex_pc;
                taken_d  = actual_taken;
                jalr_d   = ex_is_jalr;
                link_d   = seq_pc;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            branch_flag_out   <= 1'b0;
            flush_out         <= 1'b0;
            branch_target_out <= '0;
            branch_pc_out     <= '0;
            branch_taken_out  <= 1'b0;
            is_jalr_out       <= 1'b0;
            link_addr_out     <= '0;
        end else begin
            branch_flag_out   <= flag_d;
            flush_out         <= flush_d;
            branch_target_out <= target_d;
            branch_pc_out     <= pc_d;
            branch_taken_out  <= taken_d;
            is_jalr_out       <= jalr_d;
            link_addr_out     <= link_d;
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating resolve/mispredict counters
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            stat_resolved_out   <= '0;
            stat_mispredict_out <= '0;
        end else if (consume) begin
            if (stat_resolved_out != 32'hFFFF_FFFF) begin
                stat_resolved_out <= stat_resolved_out + 32'd1;
            end
            if (mispredict && (stat_mispredict_out != 32'hFFFF_FFFF)) begin
                stat_mispredict_out <= stat_mispredict_out + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed vector table, hand-written corner sequences and
// randomized traffic checked against a cycle-level reference model.
module tb_branch_resolver;

    localparam int unsigned AW = 32;
    localparam int unsigned SC = 2;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in, stall_ex, ex_valid;
    logic [AW-1:0] ex_pc, ex_rs1, ex_rs2, ex_imm, ex_pred_target;
    logic          ex_is_branch, ex_is_jal, ex_is_jalr, ex_pred_taken;
    logic [2:0]    ex_funct3;
    logic          branch_flag_out, branch_taken_out, is_jalr_out, flush_out;
    logic [AW-1:0] branch_target_out, branch_pc_out, link_addr_out;
`ifdef BRANCH_STATS_EN
    logic [31:0]   stat_resolved_out, stat_mispredict_out;
`endif

    always #5 clk_in = ~clk_in;

    branch_resolver #(.ADDR_WIDTH(AW), .SQUASH_CYCLES(SC)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .stall_ex(stall_ex),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .branch_flag_out(branch_flag_out), .branch_target_out(branch_target_out),
        .branch_pc_out(branch_pc_out), .branch_taken_out(branch_taken_out),
        .is_jalr_out(is_jalr_out), .link_addr_out(link_addr_out),
`ifdef BRANCH_STATS_EN
        .stat_resolved_out(stat_resolved_out), .stat_mispredict_out(stat_mispredict_out),
`endif
        .flush_out(flush_out)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic          m_flag, m_flush, m_taken, m_jalr;
    logic [AW-1:0] m_target, m_pc, m_link;
    int            m_rem;
    logic [31:0]   m_res, m_mis;

    typedef struct {
        logic          taken;
        logic [AW-1:0] next_pc;
        logic          mis;
    } res_t;

    typedef struct {
        string         name;
        logic [AW-1:0] pc;
        logic [2:0]    kind;      // {jalr, jal, branch}
        logic [2:0]    f3;
        logic [AW-1:0] rs1, rs2, imm;
        logic          pt;
        logic [AW-1:0] ptgt;
        logic          e_flag;
        logic [AW-1:0] e_target;
        logic          e_taken;
        logic [AW-1:0] e_link;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t resolve();
        res_t r;
        logic c;
        logic [AW-1:0] tgt;
        case (ex_funct3)
            3'd0: c = (ex_rs1 == ex_rs2);
            3'd1: c = (ex_rs1 != ex_rs2);
            3'd4: c = ($signed(ex_rs1) < $signed(ex_rs2));
            3'd5: c = !($signed(ex_rs1) < $signed(ex_rs2));
            3'd6: c = (ex_rs1 < ex_rs2);
            3'd7: c = !(ex_rs1 < ex_rs2);
            default: c = 1'b0;
        endcase
        r.taken   = ex_is_jal || ex_is_jalr || (ex_is_branch && c);
        tgt       = ex_is_jalr ? ((ex_rs1 + ex_imm) & 32'hFFFF_FFFE) : (ex_pc + ex_imm);
        r.next_pc = r.taken ? tgt : ex_pc + 32'd4;
        r.mis     = (r.taken != ex_pred_taken) || (r.taken && (tgt != ex_pred_target));
        return r;
    endfunction

    // One clock: advance the model from the inputs seen at the edge, then compare
    task automatic tick();
        res_t r;
        logic cf;
        r  = resolve();
        cf = ex_is_branch || ex_is_jal || ex_is_jalr;
        @(posedge clk_in);
        #1;
        if (!rst_in) begin
            m_flag = 0; m_flush = 0; m_taken = 0; m_jalr = 0;
            m_target = '0; m_pc = '0; m_link = '0; m_rem = 0; m_res = 0; m_mis = 0;
        end else if (rdy_in) begin
            m_flag = 0;
            if (m_flush) begin
                if (m_rem > 0) begin
                    m_rem--;
                end else begin
                    m_flush = 0;
                end
            end else if (ex_valid && !stall_ex && cf) begin
                m_target = r.next_pc;
                m_pc     = ex_pc;
                m_taken  = r.taken;
                m_jalr   = ex_is_jalr;
                m_link   = ex_pc + 32'd4;
                if (m_res != 32'hFFFF_FFFF) m_res++;
                if (r.mis) begin
                    m_flag  = 1;
                    m_flush = 1;
                    m_rem   = SC;
                    if (m_mis != 32'hFFFF_FFFF) m_mis++;
                end
            end
        end
        chk("model_flag", 32'(branch_flag_out), 32'(m_flag));
        chk("model_flush", 32'(flush_out), 32'(m_flush));
        chk("model_target", branch_target_out, m_target);
        chk("model_pc", branch_pc_out, m_pc);
        chk("model_taken", 32'(branch_taken_out), 32'(m_taken));
        chk("model_jalr", 32'(is_jalr_out), 32'(m_jalr));
        chk("model_link", link_addr_out, m_link);
`ifdef BRANCH_STATS_EN
        chk("model_stat_resolved", stat_resolved_out, m_res);
        chk("model_stat_mispredict", stat_mispredict_out, m_mis);
`endif
    endtask

    task automatic drive(input logic [AW-1:0] pc, input logic [2:0] kind, input logic [2:0] f3,
                         input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] imm, input logic pt, input logic [AW-1:0] ptgt);
        ex_valid = 1; ex_pc = pc;
        ex_is_branch = kind[0]; ex_is_jal = kind[1]; ex_is_jalr = kind[2];
        ex_funct3 = f3; ex_rs1 = rs1; ex_rs2 = rs2; ex_imm = imm;
        ex_pred_taken = pt; ex_pred_target = ptgt;
    endtask

    vec_t vecs[10];

    initial begin
        rst_in = 0; rdy_in = 1; stall_ex = 0; ex_valid = 0;
        drive('0, 3'b000, 3'd0, '0, '0, '0, 1'b0, '0);
        ex_valid = 0;

        // Reset state
        tick(); tick();
        chk("reset_flag", 32'(branch_flag_out), 32'd0);
        chk("reset_flush", 32'(flush_out), 32'd0);
        chk("reset_target", branch_target_out, 32'd0);
        chk("reset_link", link_addr_out, 32'd0);
        rst_in = 1;
        tick();

        vecs[0] = '{"beq_mis", 32'h100, 3'b001, 3'd0, 32'd5, 32'd5, 32'h20, 1'b0, 32'h0,
                    1'b1, 32'h120, 1'b1, 32'h104};
        vecs[1] = '{"bne_nt", 32'h200, 3'b001, 3'd1, 32'd7, 32'd7, 32'h40, 1'b0, 32'h0,
                    1'b0, 32'h204, 1'b0, 32'h204};
        vecs[2] = '{"jalr_lsb", 32'h300, 3'b100, 3'd0, 32'h1003, 32'd0, 32'h0, 1'b1, 32'h1000,
                    1'b1, 32'h1002, 1'b1, 32'h304};
        vecs[3] = '{"blt_signed", 32'h400, 3'b001, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 32'h410,
                    1'b0, 32'h410, 1'b1, 32'h404};
        vecs[4] = '{"bltu_unsigned", 32'h400, 3'b001, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h0,
                    1'b0, 32'h404, 1'b0, 32'h404};
        vecs[5] = '{"b_wrap", 32'hFFFF_FFF0, 3'b001, 3'd0, 32'd0, 32'd0, 32'h20, 1'b1, 32'h10,
                    1'b0, 32'h10, 1'b1, 32'hFFFF_FFF4};
        vecs[6] = '{"jal_back", 32'h500, 3'b010, 3'd0, 32'd0, 32'd0, 32'hFFFF_FF00, 1'b1, 32'h400,
                    1'b0, 32'h400, 1'b1, 32'h504};
        vecs[7] = '{"bge_mis", 32'h600, 3'b001, 3'd5, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 32'h610,
                    1'b1, 32'h604, 1'b0, 32'h604};
        vecs[8] = '{"f3_010_nt", 32'h700, 3'b001, 3'd2, 32'd0, 32'd0, 32'h8, 1'b0, 32'h0,
                    1'b0, 32'h704, 1'b0, 32'h704};
        vecs[9] = '{"jal_tgt_mis", 32'h800, 3'b010, 3'd0, 32'd0, 32'd0, 32'h40, 1'b1, 32'h844,
                    1'b1, 32'h840, 1'b1, 32'h804};

        foreach (vecs[i]) begin
            drive(vecs[i].pc, vecs[i].kind, vecs[i].f3, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].imm, vecs[i].pt, vecs[i].ptgt);
            tick();
            chk({vecs[i].name, "_flag"}, 32'(branch_flag_out), 32'(vecs[i].e_flag));
            chk({vecs[i].name, "_target"}, branch_target_out, vecs[i].e_target);
            chk({vecs[i].name, "_taken"}, 32'(branch_taken_out), 32'(vecs[i].e_taken));
            chk({vecs[i].name, "_link"}, link_addr_out, vecs[i].e_link);
            chk({vecs[i].name, "_pc"}, branch_pc_out, vecs[i].pc);
            chk({vecs[i].name, "_jalr"}, 32'(is_jalr_out), 32'(vecs[i].kind[2]));
            chk({vecs[i].name, "_flush"}, 32'(flush_out), 32'(vecs[i].e_flag));
            ex_valid = 0;
            for (int k = 1; k <= int'(SC) + 1; k++) begin
                tick();
                chk({vecs[i].name, "_drain_flag"}, 32'(branch_flag_out), 32'd0);
                chk({vecs[i].name, "_drain_flush"}, 32'(flush_out),
                    32'(vecs[i].e_flag && (k <= int'(SC))));
            end
        end
`ifdef BRANCH_STATS_EN
        chk("stat_resolved_table", stat_resolved_out, 32'd10);
        chk("stat_mispredict_table", stat_mispredict_out, 32'd4);
`endif

        // Wrong-path branch in REDIRECT is dropped; reset during SQUASH returns to IDLE
        drive(32'h100, 3'b001, 3'd0, 32'd5, 32'd5, 32'h20, 1'b0, 32'h0);
        tick();
        chk("seq5_flag", 32'(branch_flag_out), 32'd1);
        drive(32'h900, 3'b001, 3'd0, 32'd1, 32'd1, 32'h40, 1'b0, 32'h0);
        tick();
        chk("seq5_dropped_flag", 32'(branch_flag_out), 32'd0);
        chk("seq5_dropped_pc", branch_pc_out, 32'h100);
        chk("seq5_squash_flush", 32'(flush_out), 32'd1);
        ex_valid = 0; rst_in = 0;
        tick();
        chk("seq5_rst_flush", 32'(flush_out), 32'd0);
        chk("seq5_rst_flag", 32'(branch_flag_out), 32'd0);
        rst_in = 1;
        drive(32'hA00, 3'b001, 3'd1, 32'd1, 32'd1, 32'h40, 1'b0, 32'h0);
        tick();
        chk("seq5_idle_consume_pc", branch_pc_out, 32'hA00);
        chk("seq5_idle_consume_flag", 32'(branch_flag_out), 32'd0);

        // rdy_in=0 holds the pulse; stall_ex does not hold REDIRECT/SQUASH
        drive(32'hB00, 3'b010, 3'd0, 32'd0, 32'd0, 32'h10, 1'b0, 32'h0);
        tick();
        ex_valid = 0; rdy_in = 0;
        tick(); tick();
        chk("rdy0_hold_flag", 32'(branch_flag_out), 32'd1);
        rdy_in = 1; stall_ex = 1;
        tick();
        chk("stall_redirect_adv_flag", 32'(branch_flag_out), 32'd0);
        chk("stall_redirect_adv_flush", 32'(flush_out), 32'd1);
        tick(); tick();
        chk("stall_squash_done", 32'(flush_out), 32'd0);
        // stall in IDLE: instruction not consumed
        drive(32'hC00, 3'b001, 3'd0, 32'd3, 32'd3, 32'h8, 1'b0, 32'h0);
        tick();
        chk("stall_idle_flag", 32'(branch_flag_out), 32'd0);
        chk("stall_idle_pc", branch_pc_out, 32'hB00);
        stall_ex = 0;
        tick();
        chk("unstall_flag", 32'(branch_flag_out), 32'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            logic [2:0] kind;
            int sel;
            sel = $urandom_range(0, 3);
            kind = (sel == 0) ? 3'b000 : 3'(1 << (sel - 1));
            drive({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, kind, 3'($urandom_range(0, 7)),
                  $urandom(), $urandom(), 32'($signed(12'($urandom()))), 1'($urandom()), $urandom());
            if ($urandom_range(0, 2) == 0) ex_rs2 = ex_rs1;
            if ($urandom_range(0, 1) == 0) ex_pred_target = resolve().next_pc;
            ex_valid = ($urandom_range(0, 9) < 7);
            stall_ex = ($urandom_range(0, 4) == 0);
            rdy_in   = ($urandom_range(0, 9) != 0);
            rst_in   = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
